// File: rtl/rf_arb_pkg.sv
// Shared state type, lock timeout and id-width helper for the register-file access arbiter.
// Supplies default RF_* data-path widths when the build does not define them.
`ifndef RF_AWIDTH
`define RF_AWIDTH 8
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif

package rf_arb_pkg;

  typedef enum logic {IDLE, LOCKED} rf_arb_state_t;

  localparam int LOCK_TIMEOUT = 16;

  // Width of a requester index; N_REQ is always at least 2.
  function automatic int rf_arb_id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/rf_arb_picker.sv
// One-hot grant picker: rotate requests by the priority pointer, isolate the lowest set bit, rotate back.
// Combinational, no backpressure; RF_ARB_ROUND_ROBIN_EN selects rotating vs fixed lowest-index priority.
module rf_arb_picker #(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic [N_REQ-1:0] req_mask,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt
);

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   gnt_rot;
  logic [2*N_REQ-1:0] gnt_dbl;

  always_comb begin
    req_dbl = {req_mask, req_mask} >> ptr;
    req_rot = req_dbl[N_REQ-1:0];
    gnt_rot = req_rot & (~req_rot + 1'b1);
    gnt_dbl = {{N_REQ{1'b0}}, gnt_rot} << ptr;
    gnt     = gnt_dbl[N_REQ-1:0] | gnt_dbl[2*N_REQ-1:N_REQ];
  end
`else
  logic unused_ptr;

  assign unused_ptr = ^ptr;
  assign gnt        = req_mask & (~req_mask + 1'b1);
`endif

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one single-port register file between N_REQ requesters (index 0 = SPI bridge), optional bus lock.
// gnt/mem_* are combinational; read data returns RD_LATENCY cycles after grant; req held until gnt.
// RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration, otherwise fixed lowest-index priority.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              lock,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*`RF_AWIDTH-1:0]   req_addr,
  input  logic [N_REQ*`RF_WIDTH-1:0]    req_wdata,
  input  logic [N_REQ*`RF_MASK-1:0]     req_wmask,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [`RF_WIDTH-1:0]          rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [`RF_AWIDTH-1:0]         mem_addr,
  output logic [`RF_WIDTH-1:0]          mem_wdata,
  output logic [`RF_MASK-1:0]           mem_wmask,
  input  logic [`RF_WIDTH-1:0]          mem_rdata
);

  localparam int IDW = rf_arb_id_w(N_REQ);
  localparam int AW  = `RF_AWIDTH;
  localparam int DW  = `RF_WIDTH;
  localparam int MW  = `RF_MASK;

  typedef logic [IDW-1:0] rf_arb_id_t;

  rf_arb_state_t    state, state_nxt;
  rf_arb_id_t       owner, owner_nxt;
  rf_arb_id_t       gnt_id;
  rf_arb_id_t       ptr;
  logic [3:0]       tmo_cnt, tmo_cnt_nxt;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] req_mask;
  logic [N_REQ-1:0] rd_pipe [RD_LATENCY];

  // While locked only the owner may compete; reset blocks every grant.
  assign owner_oh = N_REQ'(1) << owner;
  assign req_mask = rst ? '0 : ((state == LOCKED) ? (req & owner_oh) : req);

  rf_arb_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req_mask (req_mask),
    .ptr      (ptr),
    .gnt      (gnt)
  );

  assign mem_en = |gnt;

  always_comb begin
    gnt_id    = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id    = rf_arb_id_t'(i);
        mem_we    = req_we[i];
        mem_addr  = req_addr[i*AW +: AW];
        mem_wdata = req_wdata[i*DW +: DW];
        mem_wmask = req_wmask[i*MW +: MW];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    tmo_cnt_nxt = tmo_cnt;
    case (state)
      IDLE: begin
        tmo_cnt_nxt = '0;
        if (mem_en && lock[gnt_id]) begin
          state_nxt = LOCKED;
          owner_nxt = gnt_id;
        end
      end
      LOCKED: begin
        if (mem_en) begin
          tmo_cnt_nxt = '0;
          if (!lock[owner]) state_nxt = IDLE;
        end else if (tmo_cnt == 4'(LOCK_TIMEOUT - 1)) begin
          // Owner has been silent for the full timeout window: release the bus.
          tmo_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

`ifdef RF_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (mem_en && state == IDLE) begin
      ptr <= (gnt_id == rf_arb_id_t'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // One-hot read owner travels alongside the memory's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= (mem_en && !mem_we) ? gnt : '0;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rvalid = rd_pipe[RD_LATENCY-1];
  assign rdata  = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural arbiter/memory model.
`ifndef RF_AWIDTH
`define RF_AWIDTH 8
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif

module tb_rf_access_arbiter;
  import rf_arb_pkg::*;

  localparam int N  = 2;
  localparam int L  = 2;
  localparam int AW = `RF_AWIDTH;
  localparam int DW = `RF_WIDTH;
  localparam int MW = `RF_MASK;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, lock, req_we, gnt, rvalid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*MW-1:0]   req_wmask;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_wmask;

  rf_access_arbiter #(.N_REQ(N), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus
  logic          s_rst;
  logic [N-1:0]  s_req, s_lock, s_we;
  logic [AW-1:0] s_addr  [N];
  logic [DW-1:0] s_wdata [N];
  logic [MW-1:0] s_wmask [N];

  // Behavioural model
  typedef struct { int due; int who; logic [DW-1:0] d; } ret_t;
  typedef struct { int due; logic [DW-1:0] d; } ram_ret_t;
  bit            m_locked;
  int            m_owner, m_idle, m_ptr, m_win;
  logic [DW-1:0] ref_mem [1<<AW];
  ret_t          exp_q[$];

  // Memory the DUT drives
  logic [DW-1:0] ram [1<<AW];
  ram_ret_t      ram_q[$];

  int cyc, checks, errors;
  logic [N-1:0]  obs_gnt, obs_rvalid;
  logic [DW-1:0] obs_rdata;
  logic [MW-1:0] obs_wmask;
  logic          obs_mem_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Winner by rule: locked -> only owner; else closest at/after pointer (or lowest index).
  function automatic int pick();
    int best = -1;
    int bd   = N;
    if (s_rst) return -1;
    for (int i = 0; i < N; i++) begin
      int d;
`ifdef RF_ARB_ROUND_ROBIN_EN
      d = (i - m_ptr + N) % N;
`else
      d = i;
`endif
      if (s_req[i] && !(m_locked && i != m_owner) && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic step();
    logic [N-1:0]  e_gnt, e_rv;
    logic [DW-1:0] e_rd;
    int w;
    @(negedge clk);
    rst = s_rst; req = s_req; lock = s_lock; req_we = s_we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = s_addr[i];
      req_wdata[i*DW +: DW] = s_wdata[i];
      req_wmask[i*MW +: MW] = s_wmask[i];
    end
    if (ram_q.size() > 0 && ram_q[0].due == cyc) mem_rdata = ram_q.pop_front().d;
    else mem_rdata = $urandom;
    #1;
    w = pick();
    m_win = w;
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    e_rv = '0;
    e_rd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (!s_rst) begin
        e_rv[exp_q[0].who] = 1'b1;
        e_rd = exp_q[0].d;
      end
      void'(exp_q.pop_front());
    end
    chk("gnt", gnt, e_gnt);
    chk("mem_en", mem_en, w >= 0);
    if (w >= 0) begin
      chk("mem_we", mem_we, s_we[w]);
      chk("mem_addr", mem_addr, s_addr[w]);
      chk("mem_wdata", mem_wdata, s_wdata[w]);
      chk("mem_wmask", mem_wmask, s_wmask[w]);
    end else begin
      chk("mem_idle", {mem_we, mem_addr, mem_wmask}, '0);
      chk("mem_wdata_idle", mem_wdata, '0);
    end
    chk("rvalid", rvalid, e_rv);
    if (|e_rv || s_rst) chk("rdata", rdata, e_rd);
    obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata; obs_wmask = mem_wmask; obs_mem_en = mem_en;
    // Memory responds to whatever the DUT put on its port.
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = merge(ram[mem_addr], mem_wdata, mem_wmask);
      else ram_q.push_back('{cyc + L, ram[mem_addr]});
    end
    // Model state at the clock edge
    if (s_rst) begin
      m_locked = 0; m_idle = 0; m_ptr = 0;
      exp_q.delete();
    end else if (w >= 0) begin
      if (s_we[w]) ref_mem[s_addr[w]] = merge(ref_mem[s_addr[w]], s_wdata[w], s_wmask[w]);
      else exp_q.push_back('{cyc + L, w, ref_mem[s_addr[w]]});
      if (!m_locked) begin
        m_ptr = (w + 1) % N;
        if (s_lock[w]) begin m_locked = 1; m_owner = w; end
      end else if (!s_lock[w]) begin
        m_locked = 0;
      end
      m_idle = 0;
    end else if (m_locked) begin
      m_idle++;
      if (m_idle == LOCK_TIMEOUT) begin m_locked = 0; m_idle = 0; end
    end
    cyc++;
  endtask

  initial begin
    logic [N-1:0] seq [4];
    logic [N-1:0] exp_seq [4];
    int  quiet_n;
    bit  seen;
    checks = 0; errors = 0; cyc = 0;
    m_locked = 0; m_owner = 0; m_idle = 0; m_ptr = 0; m_win = -1;
    for (int i = 0; i < (1<<AW); i++) begin ram[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; req = '0; lock = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    mem_rdata = '0;
    s_rst = 1'b1; s_req = 2'b11; s_lock = '0; s_we = '0;
    for (int i = 0; i < N; i++) begin s_addr[i] = '0; s_wdata[i] = '0; s_wmask[i] = '0; end

    // Reset with both requesting
    step(); step();
    chk("reset_gnt", obs_gnt, 2'b00);
    chk("reset_mem_en", obs_mem_en, 1'b0);
    chk("reset_rvalid", obs_rvalid, 2'b00);

    // Release: SPI bridge first
    s_rst = 1'b0; s_we = 2'b11;
    s_addr[0] = 8'd5; s_wdata[0] = 32'hDEADBEEF; s_wmask[0] = 4'hF;
    s_addr[1] = 8'd9; s_wdata[1] = 32'h12345678; s_wmask[1] = 4'h3;
    step(); chk("release_gnt", obs_gnt, 2'b01);
    s_req = 2'b10; step(); chk("second_gnt", obs_gnt, 2'b10);

    // Single read of addr 5 by requester 1
    s_we[1] = 1'b0; s_addr[1] = 8'd5;
    step(); chk("read_gnt", obs_gnt, 2'b10);
    s_req = 2'b00; step(); chk("read_wait", obs_rvalid, 2'b00);
    step();
    chk("read_rvalid", obs_rvalid, 2'b10);
    chk("read_rdata", obs_rdata, 32'hDEADBEEF);

    // Contention, both writing, held 4 cycles
    s_req = 2'b11; s_we = 2'b11; s_addr[1] = 8'd9;
`ifdef RF_ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int k = 0; k < 4; k++) begin step(); seq[k] = obs_gnt; end
    for (int k = 0; k < 4; k++) chk($sformatf("contend_gnt%0d", k), seq[k], exp_seq[k]);

    // Locked burst by requester 1 while SPI bridge waits
    s_req = 2'b10; s_lock = 2'b10; s_addr[1] = 8'd0; s_wdata[1] = 32'hA0A0A0A0; s_wmask[1] = 4'hF;
    step(); seq[0] = obs_gnt;
    s_req = 2'b11; s_addr[1] = 8'd1; step(); seq[1] = obs_gnt;
    s_lock = 2'b00; s_addr[1] = 8'd2; step(); seq[2] = obs_gnt;
    chk("burst_wmask", obs_wmask, 4'hF);
    s_req = 2'b01; step(); seq[3] = obs_gnt;
    chk("burst_gnt0", seq[0], 2'b10);
    chk("burst_gnt1", seq[1], 2'b10);
    chk("burst_gnt2", seq[2], 2'b10);
    chk("burst_gnt3", seq[3], 2'b01);

    // Lock timeout: owner goes silent
    s_req = 2'b10; s_lock = 2'b10; step(); chk("tmo_lock_gnt", obs_gnt, 2'b10);
    s_req = 2'b01; s_lock = 2'b00; quiet_n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_gnt != 2'b00) break;
      quiet_n++;
    end
    chk("tmo_quiet_cycles", quiet_n, 16);
    chk("tmo_release_gnt", obs_gnt, 2'b01);

    // Pipelined reads
    s_req = 2'b01; s_we = 2'b00; s_addr[0] = 8'd5; s_addr[1] = 8'd9; step();
    s_req = 2'b10; step();
    s_req = 2'b00; step();
    chk("pipe_rvalid0", obs_rvalid, 2'b01);
    chk("pipe_rdata0", obs_rdata, 32'hDEADBEEF);
    step();
    chk("pipe_rvalid1", obs_rvalid, 2'b10);
    chk("pipe_rdata1", obs_rdata, 32'h00005678);

    // Reset while a read is in flight
    s_req = 2'b01; step();
    s_req = 2'b10; s_rst = 1'b1; step();
    s_req = 2'b00; s_rst = 1'b0; seen = 0;
    for (int k = 0; k < 4; k++) begin step(); seen |= |obs_rvalid; end
    chk("reset_drops_rvalid", seen, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      s_rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!s_req[i] && $urandom_range(0, (i == 1 && (c / 400) % 2 == 1) ? 23 : 2) != 0) begin
          s_req[i]   = 1'b1;
          s_we[i]    = 1'($urandom);
          s_lock[i]  = ($urandom_range(0, 3) == 0);
          s_addr[i]  = AW'($urandom_range(0, 15));
          s_wdata[i] = $urandom;
          s_wmask[i] = MW'($urandom);
        end
      end
      step();
      if (m_win >= 0) s_req[m_win] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
